alu_console: RTL

Parametrised front-panel controller for the ALU on the Basys3. It sits between the raw switches, buttons and LEDs and the ALU ports. It debounces the buttons and latches full-width operands A and B from the switches. It steps through opcodes, runs a single ALU operation with a handshake and configurable latency, and shows the selected operand, opcode or result on the LEDs, with the flags on separate LEDs. Optional chain mode feeds each result back into A for accumulator-style use.

---
 rtl/alu_console.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/alu_console.sv
// Front-panel controller for a Basys3 ALU: debounced buttons load operands, step the
// opcode and launch one ALU operation, with the selected register shown on the LEDs.
module alu_console #(
   parameter int WIDTH           = 16,
   parameter int OP_WIDTH        = 4,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int ALU_LAT         = 1,
   parameter int CHAIN_EN        = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [WIDTH-1:0]    sw,
   input  logic                btnu,
   input  logic                btnl,
   input  logic                btnd,
   input  logic                btnr,
   output logic [WIDTH-1:0]    led,
   output logic [2:0]          flag_led,
   output logic                busy,
   output logic [WIDTH-1:0]    alu_a,
   output logic [WIDTH-1:0]    alu_b,
   output logic [OP_WIDTH-1:0] alu_op,
   output logic                alu_enable,
   input  logic [WIDTH-1:0]    alu_result,
   input  logic                alu_zero,
   input  logic                alu_carry,
   input  logic                alu_overflow
);

   localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int LAT_W = $clog2(ALU_LAT + 1);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WAIT, S_CAPTURE} state_t;
   typedef enum logic [1:0] {V_A, V_B, V_OP, V_RES} view_t;

   // Button index: 3 = execute, 2 = load A, 1 = load B, 0 = next op (also the priority order).
   logic [3:0]      btn_raw;
   logic [3:0]      sync1_q, sync2_q, db_q, press_q;
   logic [DB_W-1:0] db_cnt_q [4];

   assign btn_raw = {btnd, btnl, btnr, btnu};

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         db_q    <= '0;
         press_q <= '0;
         for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         press_q <= '0;
         for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] != db_q[i]) begin
               if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                  db_q[i]     <= sync2_q[i];
                  db_cnt_q[i] <= '0;
                  press_q[i]  <= sync2_q[i];
               end else begin
                  db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
               end
            end else begin
               db_cnt_q[i] <= '0;
            end
         end
      end
   end

   state_t              state_q, state_d;
   view_t               view_q, view_d;
   logic [LAT_W-1:0]    wcnt_q, wcnt_d;
   logic [WIDTH-1:0]    a_q, a_d, b_q, b_d, res_q, res_d;
   logic [OP_WIDTH-1:0] op_q, op_d;
   logic [2:0]          flags_q, flags_d;

   // ALU handshake: alu_enable is a one-cycle strobe in EXEC with operands held steady;
   // alu_result and flags are taken unconditionally ALU_LAT cycles later in CAPTURE.
   always_comb begin
      state_d = state_q;
      view_d  = view_q;
      wcnt_d  = wcnt_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      res_d   = res_q;
      flags_d = flags_q;
      case (state_q)
         S_IDLE: begin
            if (press_q[3]) begin
               state_d = S_EXEC;
            end else if (press_q[2]) begin
               a_d    = sw;
               view_d = V_A;
            end else if (press_q[1]) begin
               b_d    = sw;
               view_d = V_B;
            end else if (press_q[0]) begin
               op_d   = op_q + 1'b1;
               view_d = V_OP;
            end
         end
         S_EXEC: begin
            wcnt_d  = LAT_W'(1);
            state_d = (ALU_LAT == 1) ? S_CAPTURE : S_WAIT;
         end
         S_WAIT: begin
            if (wcnt_q == LAT_W'(ALU_LAT - 1)) state_d = S_CAPTURE;
            else wcnt_d = wcnt_q + 1'b1;
         end
         S_CAPTURE: begin
            res_d   = alu_result;
            flags_d = {alu_overflow, alu_carry, alu_zero};
            view_d  = V_RES;
            if (CHAIN_EN != 0) a_d = alu_result;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         view_q  <= V_RES;
         wcnt_q  <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         res_q   <= '0;
         flags_q <= '0;
      end else begin
         state_q <= state_d;
         view_q  <= view_d;
         wcnt_q  <= wcnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         res_q   <= res_d;
         flags_q <= flags_d;
      end
   end

   assign busy       = (state_q != S_IDLE);
   assign alu_enable = (state_q == S_EXEC);
   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign alu_op     = op_q;
   assign flag_led   = flags_q;

   always_comb begin
      led = res_q;
      case (view_q)
         V_A:     led = a_q;
         V_B:     led = b_q;
         V_OP:    led = WIDTH'(op_q);
         default: led = res_q;
      endcase
   end

endmodule
